sync_fifo: RTL and testbench

//   Single-clock, RTL-coded FIFO that sits between a producer (fifo_write) and a consumer (fifo_read).
//   It is a drop-in native replacement for the vendor FIFO core in the FIFO loop-back design.
//   It provides the same full, almost_full, empty and almost_empty handshake flags plus data counts.
//   It adds overflow and underflow error pulses for debug.

---
 rtl/sync_fifo.sv | 173 +++++++++++++++++
 tb/tb_sync_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO between a producer and a consumer. Native replacement
//   for a vendor FIFO core: registered full/almost_full/empty/almost_empty
//   flags, an exact data count, a registered read port with a valid pulse, a
//   write acknowledge pulse, and overflow/underflow error pulses.
//
// Ports
//   sys_clk       in   clock, rising edge
//   sys_rst       in   asynchronous reset, active-high
//   wr_en / din   in   write request and write data
//   rd_en         in   read request
//   dout          out  registered read data (holds when no read is accepted)
//   valid         out  dout was updated by an accepted read this cycle
//   wr_ack        out  previous cycle's write was accepted
//   full          out  data_count == DEPTH
//   almost_full   out  data_count >= AF_LEVEL
//   empty         out  data_count == 0
//   almost_empty  out  data_count <= AE_LEVEL
//   data_count    out  stored words, 0..DEPTH
//   overflow      out  a write was rejected because the FIFO was full
//   underflow     out  a read was rejected because the FIFO was empty
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = 255,
  parameter int AE_LEVEL = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              wr_ack,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Storage: one synchronous write port, one read port feeding dout_q.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              empty_q, empty_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_acc;
  logic              rd_acc;

  // Acceptance is judged on the registered flags, so a simultaneous
  // read frees no room for a write when full, and a simultaneous write
  // provides no data for a read when empty.
  always_comb begin
    wr_acc = wr_en & ~full_q;
    rd_acc = rd_en & ~empty_q;
  end

  // Next-state for pointers, count, read data, flags and pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      dout_d   = mem[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Flags follow the next count so they are exact one cycle after access.
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AF_C);
    empty_d  = (count_d == {CNT_W{1'b0}});
    aempty_d = (count_d <= AE_C);

    valid_d  = rd_acc;
    wr_ack_d = wr_acc;
    ovf_d    = wr_en & full_q;
    udf_d    = rd_en & empty_q;
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      dout_q   <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      wr_ack_q <= wr_ack_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dout         = dout_q;
    valid        = valid_q;
    wr_ack       = wr_ack_q;
    full         = full_q;
    almost_full  = afull_q;
    empty        = empty_q;
    almost_empty = aempty_q;
    data_count   = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Directed test bench for sync_fifo (DATA_W=8, ADDR_W=8, AF=255, AE=1).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  logic       sys_clk;
  logic       sys_rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       valid;
  logic       wr_ack;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       almost_empty;
  logic [8:0] data_count;
  logic       overflow;
  logic       underflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  sync_fifo #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .AF_LEVEL (255),
    .AE_LEVEL (1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .wr_ack       (wr_ack),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Single comparison point: counts the vector, reports a miscompare.
  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = 8'h00;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_vec({tag, "_cnt"},    32'(data_count),   32'd0);
    check_vec({tag, "_dout"},   32'(dout),         32'h0);
    check_vec({tag, "_empty"},  32'(empty),        32'd1);
    check_vec({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    check_vec({tag, "_full"},   32'(full),         32'd0);
    check_vec({tag, "_afull"},  32'(almost_full),  32'd0);
    check_vec({tag, "_pulses"},
              32'({valid, wr_ack, overflow, underflow}), 32'h0);
  endtask

  initial begin
    int exp_q[$];
    int rd_seen;

    sys_rst = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = 8'h00;
    #2;
    do_reset();
    check_reset_state("rst0");

    // Test 1: five writes then five reads.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h11 + i);
      tick();
      check_vec("t1_wr_ack", 32'(wr_ack), 32'd1);
      check_vec("t1_wr_cnt", 32'(data_count), 32'(i + 1));
    end
    wr_en = 1'b0;
    check_vec("t1_aempty5", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick();
      check_vec("t1_valid", 32'(valid), 32'd1);
      check_vec("t1_dout",  32'(dout),  32'(8'h11 + i));
    end
    rd_en = 1'b0;
    tick();
    check_vec("t1_valid_end", 32'(valid),      32'd0);
    check_vec("t1_empty_end", 32'(empty),      32'd1);
    check_vec("t1_cnt_end",   32'(data_count), 32'd0);
    check_vec("t1_dout_hold", 32'(dout),       32'h15);

    // Test 3: read while empty from reset state.
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_vec("t3_udf",   32'(underflow), 32'd1);
    check_vec("t3_dout",  32'(dout),      32'h0);
    check_vec("t3_valid", 32'(valid),     32'd0);
    tick();
    check_vec("t3_udf_pulse", 32'(underflow), 32'd0);

    // Simultaneous write+read while empty: write wins, no bypass.
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_vec("t3b_udf",   32'(underflow),  32'd1);
    check_vec("t3b_ack",   32'(wr_ack),     32'd1);
    check_vec("t3b_cnt",   32'(data_count), 32'd1);
    check_vec("t3b_valid", 32'(valid),      32'd0);
    check_vec("t3b_dout",  32'(dout),       32'h0);

    // Test 2: fill with 0x00..0xFF.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      tick();
      check_vec("t2_afull", 32'(almost_full), 32'((i + 1) >= 255));
      check_vec("t2_full",  32'(full),        32'((i + 1) == 256));
    end
    check_vec("t2_cnt_full", 32'(data_count), 32'd256);
    din = 8'hAA;
    tick();
    check_vec("t2_ovf",     32'(overflow),   32'd1);
    check_vec("t2_ovf_ack", 32'(wr_ack),     32'd0);
    check_vec("t2_ovf_cnt", 32'(data_count), 32'd256);
    wr_en = 1'b0;
    tick();
    check_vec("t2_ovf_pulse", 32'(overflow),   32'd0);
    check_vec("t2_cnt_hold",  32'(data_count), 32'd256);

    // Test 4: full, then write+read together for three cycles.
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 8'(8'hC0 + k);
      tick();
      check_vec("t4_dout",  32'(dout),       32'(k));
      check_vec("t4_valid", 32'(valid),      32'd1);
      check_vec("t4_ovf",   32'(overflow),   32'(k == 0));
      check_vec("t4_cnt",   32'(data_count), 32'd255);
      check_vec("t4_full",  32'(full),       32'd0);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Test 5: 600-word stream, writes one cycle ahead of reads.
    do_reset();
    rd_seen = 0;
    for (int c = 0; c <= 600; c++) begin
      wr_en = (c < 600);
      rd_en = (c > 0);
      din   = 8'(c * 7 + 3);
      if (c < 600) exp_q.push_back((c * 7 + 3) & 255);
      tick();
      if (valid) begin
        if (exp_q.size() == 0) begin
          check_vec("t5_extra_valid", 32'd1, 32'd0);
        end else begin
          check_vec("t5_dout", 32'(dout), 32'(exp_q.pop_front()));
        end
        rd_seen++;
      end
      check_vec("t5_cnt_le2", 32'(data_count <= 9'd2), 32'd1);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_vec("t5_reads", 32'(rd_seen), 32'd600);
    check_vec("t5_empty", 32'(empty),   32'd1);

    // Test 6: asynchronous reset with 100 words stored.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h40 + i);
      tick();
    end
    check_vec("t6_cnt100", 32'(data_count), 32'd100);
    rd_en = 1'b1;
    tick();
    check_vec("t6_pre_dout", 32'(dout), 32'h40);
    #3;
    sys_rst = 1'b1;
    #1;
    check_reset_state("t6_async");
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    sys_rst = 1'b0;
    wr_en   = 1'b1;
    din     = 8'h5A;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_vec("t6_new_valid", 32'(valid), 32'd1);
    check_vec("t6_new_dout",  32'(dout),  32'h5A);
    check_vec("t6_new_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
